// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO controller.
//
// Contents:
//   fifo_depth()       - number of words for a given address width
//   ADDR_SIZE_DEF      - default memory address width
//   DATA_SIZE_DEF      - default data word width
//   AFULL_THRESH_DEF   - default almost_full threshold (depth - 2)
//   AEMPTY_THRESH_DEF  - default almost_empty threshold
//   ptr_t              - wrap pointer type at the default address width
//                        (address bits plus one wrap bit)

package fifo_pkg;

    localparam int ADDR_SIZE_DEF = 4;
    localparam int DATA_SIZE_DEF = 8;

    function automatic int fifo_depth(input int addr_size);
        return 1 << addr_size;
    endfunction

    localparam int AFULL_THRESH_DEF  = fifo_depth(ADDR_SIZE_DEF) - 2;
    localparam int AEMPTY_THRESH_DEF = 2;

    typedef logic [ADDR_SIZE_DEF:0] ptr_t;

endpackage

// File: rtl/fifo_ptr_cnt.sv
// Wrap pointer for the FIFO controller: a free-running up-counter that
// advances by one when inc is high and wraps modulo 2**width.
//
// Ports:
//   clk  in   clock, state on rising edge
//   rst  in   synchronous active-high reset, clears the pointer to 0
//   inc  in   advance the pointer this cycle
//   ptr  out  registered pointer value [width-1:0]

module fifo_ptr_cnt
    import fifo_pkg::*;
#(
    parameter int width = ADDR_SIZE_DEF + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [width-1:0] ptr
);

    logic [width-1:0] ptr_q;
    logic [width-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            ptr_d = ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/fifo_sync_ctrl.sv
// Single-clock FIFO controller sequencing an external dual-port storage
// array (synchronous write, combinational read gated by rd_en).
//
// Optional feature macro: FIFO_SYNC_CTRL_ERR_FLAGS_EN
//   When defined, adds sticky overflow/underflow outputs that are cleared
//   only by rst. When undefined, dropped pushes/pops are silent.
//
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   push, din        producer write request and data
//   pop              consumer read request
//   dout, dout_valid registered read data, one-cycle valid pulse
//   full, empty      occupancy at depth / zero
//   almost_full      count >= afull_thresh
//   almost_empty     count <= aempty_thresh
//   count            occupancy, addr_size+1 bits
//   mem_wr_*         write strobe/address/data to the storage array
//   mem_rd_*         read enable/address to, data from the storage array
//   overflow         (macro only) sticky, push seen while full
//   underflow        (macro only) sticky, pop seen while empty

module fifo_sync_ctrl
    import fifo_pkg::*;
#(
    parameter int addr_size     = ADDR_SIZE_DEF,
    parameter int data_size     = DATA_SIZE_DEF,
    parameter int afull_thresh  = fifo_depth(addr_size) - 2,
    parameter int aempty_thresh = AEMPTY_THRESH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [data_size-1:0] din,
    input  logic                 pop,
    output logic [data_size-1:0] dout,
    output logic                 dout_valid,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [addr_size:0]   count,
    output logic                 mem_wr_en,
    output logic [addr_size-1:0] mem_wr_addr,
    output logic [data_size-1:0] mem_wr_data,
    output logic                 mem_rd_en,
    output logic [addr_size-1:0] mem_rd_addr,
`ifdef FIFO_SYNC_CTRL_ERR_FLAGS_EN
    output logic                 overflow,
    output logic                 underflow,
`endif
    input  logic [data_size-1:0] mem_rd_data
);

    localparam int PW = addr_size + 1;

    localparam logic [addr_size:0] DEPTH_C   = PW'(fifo_depth(addr_size));
    localparam logic [addr_size:0] AFULL_C   = PW'(afull_thresh);
    localparam logic [addr_size:0] AEMPTY_C  = PW'(aempty_thresh);

    logic [addr_size:0]   wr_ptr;
    logic [addr_size:0]   rd_ptr;
    logic [addr_size:0]   count_w;
    logic                 full_w;
    logic                 empty_w;
    logic                 push_acc;
    logic                 pop_acc;

    logic [data_size-1:0] dout_q;
    logic [data_size-1:0] dout_d;
    logic                 dout_valid_q;
    logic                 dout_valid_d;

    // Occupancy and flags come only from registered pointers, so no
    // combinational path exists from push/pop to any flag.
    assign count_w = wr_ptr - rd_ptr;
    assign full_w  = (count_w == DEPTH_C);
    assign empty_w = (count_w == '0);

    // Reset dominates: a push or pop in the reset cycle is neither
    // accepted nor allowed to strobe the memory.
    assign push_acc = push & ~full_w & ~rst;
    assign pop_acc  = pop & ~empty_w & ~rst;

    fifo_ptr_cnt #(
        .width (PW)
    ) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (push_acc),
        .ptr (wr_ptr)
    );

    fifo_ptr_cnt #(
        .width (PW)
    ) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (pop_acc),
        .ptr (rd_ptr)
    );

    assign mem_wr_en   = push_acc;
    assign mem_wr_addr = wr_ptr[addr_size-1:0];
    assign mem_wr_data = din;
    assign mem_rd_en   = pop_acc;
    assign mem_rd_addr = rd_ptr[addr_size-1:0];

    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        if (pop_acc) begin
            dout_d       = mem_rd_data;
            dout_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout         = dout_q;
    assign dout_valid   = dout_valid_q;
    assign count        = count_w;
    assign full         = full_w;
    assign empty        = empty_w;
    assign almost_full  = (count_w >= AFULL_C);
    assign almost_empty = (count_w <= AEMPTY_C);

`ifdef FIFO_SYNC_CTRL_ERR_FLAGS_EN
    logic overflow_q;
    logic overflow_d;
    logic underflow_q;
    logic underflow_d;

    always_comb begin
        overflow_d  = overflow_q | (push & full_w);
        underflow_d = underflow_q | (pop & empty_w);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule
